// File: rtl/periodic_match_scanner.sv
// periodic_match_scanner
// Scans a 48-bit memory-dump word stream for runs of words that repeat with a
// fixed period. Each armed word is sent to an external comparator with the word
// PERIOD positions earlier. A run of RUN_LEN equal results produces a hit record
// that carries the index of the first word in the run.
// Optional feature: define PMS_MATCH_COUNT_EN to build a saturating 32-bit
// counter of equal results on match_count. Otherwise match_count is tied to 0.
module periodic_match_scanner #(
  parameter int PERIOD  = 4,
  parameter int RUN_LEN = 8,
  parameter int LATENCY = 2,
  parameter int IDX_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [47:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [47:0]       cmp_a,
  output logic [47:0]       cmp_b,
  input  logic              cmp_equal,
  output logic              hit_valid,
  input  logic              hit_ready,
  output logic [IDX_W-1:0]  hit_addr,
  output logic              hit_overflow,
  output logic [31:0]       match_count
);

  localparam int FILL_W = $clog2(PERIOD + 1);
  localparam int RUN_W  = $clog2(RUN_LEN + 1);

  // history, index and fill tracking
  logic [47:0]       hist_q [PERIOD];
  logic [47:0]       hist_d [PERIOD];
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // comparator operand registers
  logic [47:0]       cmp_a_q, cmp_a_d;
  logic [47:0]       cmp_b_q, cmp_b_d;

  // issue tag pipeline, stage 0 is aligned with cmp_a/cmp_b
  logic [LATENCY:0]  tag_v_q, tag_v_d;
  logic [IDX_W-1:0]  tag_idx_q [0:LATENCY];
  logic [IDX_W-1:0]  tag_idx_d [0:LATENCY];

  // run tracking and hit record
  logic [RUN_W-1:0]  run_q, run_d;
  logic              hit_valid_q, hit_valid_d;
  logic [IDX_W-1:0]  hit_addr_q, hit_addr_d;
  logic              hit_ovf_q, hit_ovf_d;

  logic              accept_s;
  logic              armed_s;
  logic              issue_s;
  logic              res_v_s;
  logic [IDX_W-1:0]  res_idx_s;
  logic              gen_hit_s;
  logic [IDX_W-1:0]  gen_addr_s;
  logic              take_s;

  // handshake and issue qualification
  assign accept_s  = in_valid && !hit_valid_q;
  assign armed_s   = (fill_q == FILL_W'(PERIOD));
  assign issue_s   = accept_s && armed_s;
  assign res_v_s   = tag_v_q[LATENCY];
  assign res_idx_s = tag_idx_q[LATENCY];
  assign take_s    = hit_valid_q && hit_ready;

  // accept words: shift history, advance index/fill, load comparator operands
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    idx_d   = idx_q;
    cmp_a_d = cmp_a_q;
    cmp_b_d = cmp_b_q;
    if (accept_s) begin
      hist_d[0] = in_data;
      for (int k = 1; k < PERIOD; k++) begin
        hist_d[k] = hist_q[k-1];
      end
      idx_d = idx_q + IDX_W'(1);
      if (armed_s) begin
        // oldest history entry is the word PERIOD positions back
        cmp_a_d = in_data;
        cmp_b_d = hist_q[PERIOD-1];
        fill_d  = fill_q;
      end else begin
        cmp_a_d = cmp_a_q;
        cmp_b_d = cmp_b_q;
        fill_d  = fill_q + FILL_W'(1);
      end
    end else begin
      hist_d  = hist_q;
    end
  end

  // delay issue tags to line up with the comparator result
  always_comb begin
    tag_v_d[0] = issue_s;
    if (issue_s) begin
      tag_idx_d[0] = idx_q;
    end else begin
      tag_idx_d[0] = tag_idx_q[0];
    end
    for (int k = 1; k <= LATENCY; k++) begin
      tag_v_d[k]   = tag_v_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end
  end

  // run counting on tagged comparator results
  always_comb begin
    run_d      = run_q;
    gen_hit_s  = 1'b0;
    gen_addr_s = res_idx_s - IDX_W'(RUN_LEN - 1);
    if (res_v_s) begin
      if (cmp_equal) begin
        if (run_q == RUN_W'(RUN_LEN - 1)) begin
          gen_hit_s = 1'b1;
          run_d     = {RUN_W{1'b0}};
        end else begin
          run_d     = run_q + RUN_W'(1);
        end
      end else begin
        run_d = {RUN_W{1'b0}};
      end
    end else begin
      run_d = run_q;
    end
  end

  // hit record: load, hand off, or drop with sticky overflow
  always_comb begin
    hit_valid_d = hit_valid_q;
    hit_addr_d  = hit_addr_q;
    hit_ovf_d   = hit_ovf_q;
    if (gen_hit_s) begin
      if (!hit_valid_q || take_s) begin
        hit_valid_d = 1'b1;
        hit_addr_d  = gen_addr_s;
      end else begin
        hit_ovf_d   = 1'b1;
      end
    end else if (take_s) begin
      hit_valid_d = 1'b0;
    end else begin
      hit_valid_d = hit_valid_q;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < PERIOD; k++) begin
        hist_q[k] <= 48'd0;
      end
      fill_q      <= {FILL_W{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      cmp_a_q     <= 48'd0;
      cmp_b_q     <= 48'd0;
      tag_v_q     <= {(LATENCY+1){1'b0}};
      for (int k = 0; k <= LATENCY; k++) begin
        tag_idx_q[k] <= {IDX_W{1'b0}};
      end
      run_q       <= {RUN_W{1'b0}};
      hit_valid_q <= 1'b0;
      hit_addr_q  <= {IDX_W{1'b0}};
      hit_ovf_q   <= 1'b0;
    end else begin
      for (int k = 0; k < PERIOD; k++) begin
        hist_q[k] <= hist_d[k];
      end
      fill_q      <= fill_d;
      idx_q       <= idx_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      tag_v_q     <= tag_v_d;
      for (int k = 0; k <= LATENCY; k++) begin
        tag_idx_q[k] <= tag_idx_d[k];
      end
      run_q       <= run_d;
      hit_valid_q <= hit_valid_d;
      hit_addr_q  <= hit_addr_d;
      hit_ovf_q   <= hit_ovf_d;
    end
  end

`ifdef PMS_MATCH_COUNT_EN
  logic [31:0] match_cnt_q, match_cnt_d;

  // saturating count of tagged equal results
  always_comb begin
    if (res_v_s && cmp_equal && (match_cnt_q != 32'hFFFF_FFFF)) begin
      match_cnt_d = match_cnt_q + 32'd1;
    end else begin
      match_cnt_d = match_cnt_q;
    end
  end

  // match counter register
  always_ff @(posedge CLK) begin
    if (RST) begin
      match_cnt_q <= 32'd0;
    end else begin
      match_cnt_q <= match_cnt_d;
    end
  end

  assign match_count = match_cnt_q;
`else
  assign match_count = 32'd0;
`endif

  assign in_ready     = !hit_valid_q;
  assign cmp_a        = cmp_a_q;
  assign cmp_b        = cmp_b_q;
  assign hit_valid    = hit_valid_q;
  assign hit_addr     = hit_addr_q;
  assign hit_overflow = hit_ovf_q;

endmodule

// File: tb/tb_periodic_match_scanner.sv
// Directed bench for periodic_match_scanner. DUT A uses default parameters;
// DUT B uses RUN_LEN=2 so a hit can be generated while the first is pending.
module tb_periodic_match_scanner;

`ifdef PMS_MATCH_COUNT_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A signals
  logic        rst = 1'b1;
  logic [47:0] in_data = 48'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] cmp_a, cmp_b;
  logic        cmp_equal;
  logic        hit_valid;
  logic        hit_ready = 1'b1;
  logic [31:0] hit_addr;
  logic        hit_overflow;
  logic [31:0] match_count;

  // DUT B signals
  logic        b_rst = 1'b1;
  logic [47:0] b_in_data = 48'd0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [47:0] b_cmp_a, b_cmp_b;
  logic        b_cmp_equal;
  logic        b_hit_valid;
  logic        b_hit_ready = 1'b0;
  logic [31:0] b_hit_addr;
  logic        b_hit_overflow;
  logic [31:0] b_match_count;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;

  periodic_match_scanner dut_a (
    .CLK(clk), .RST(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_equal(cmp_equal),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_addr(hit_addr),
    .hit_overflow(hit_overflow), .match_count(match_count)
  );

  periodic_match_scanner #(.RUN_LEN(2)) dut_b (
    .CLK(clk), .RST(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .cmp_a(b_cmp_a), .cmp_b(b_cmp_b), .cmp_equal(b_cmp_equal),
    .hit_valid(b_hit_valid), .hit_ready(b_hit_ready), .hit_addr(b_hit_addr),
    .hit_overflow(b_hit_overflow), .match_count(b_match_count)
  );

  // two-stage comparator models (input reg + P reg)
  logic eq_a1 = 1'b0, eq_a2 = 1'b0, eq_b1 = 1'b0, eq_b2 = 1'b0;
  always @(posedge clk) begin
    eq_a1 <= (cmp_a == cmp_b);
    eq_a2 <= eq_a1;
    eq_b1 <= (b_cmp_a == b_cmp_b);
    eq_b2 <= eq_b1;
  end
  assign cmp_equal   = eq_a2;
  assign b_cmp_equal = eq_b2;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // log every cycle DUT A shows a hit
  int          hv_edge_q[$];
  logic [31:0] hv_addr_q[$];
  always @(negedge clk) begin
    if (hit_valid) begin
      hv_edge_q.push_back(edge_cnt);
      hv_addr_q.push_back(hit_addr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_a();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic feed(input logic [47:0] w, output int acc_edge);
    int waited;
    waited = 0;
    in_data = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL feed_timeout in_ready=%0b required=1", in_ready);
      acc_edge = -1;
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc_edge = edge_cnt;
      in_valid = 1'b0;
    end
  endtask

  task automatic test_basic();
    int acc[16];
    int base, n;
    base = hv_edge_q.size();
    hit_ready = 1'b1;
    for (int i = 0; i < 16; i++) feed(48'(i % 4), acc[i]);
    repeat (8) @(posedge clk);
    #1;
    n = hv_edge_q.size() - base;
    total++; if (n !== 1) begin bad++; $display("FAIL basic_hit_cycles got=%0d exp=1", n); end
    if (n >= 1) begin
      total++; if (hv_addr_q[base] !== 32'd4) begin bad++; $display("FAIL basic_hit_addr got=%0d exp=4", hv_addr_q[base]); end
      total++; if (hv_edge_q[base] !== acc[11] + 3) begin bad++; $display("FAIL basic_hit_time got=%0d exp=%0d", hv_edge_q[base], acc[11] + 3); end
    end
    total++; if (match_count !== (MC_EN ? 32'd12 : 32'd0)) begin bad++; $display("FAIL basic_match_count got=%0d exp=%0d", match_count, MC_EN ? 12 : 0); end
    total++; if (hit_overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%0b exp=0", hit_overflow); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 48'h0000_ABCD_0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    total++; if (hit_valid !== 1'b0) begin bad++; $display("FAIL reset_hit_valid got=%0b exp=0", hit_valid); end
    total++; if (hit_addr !== 32'd0) begin bad++; $display("FAIL reset_hit_addr got=%0d exp=0", hit_addr); end
    total++; if (hit_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", hit_overflow); end
    total++; if (cmp_a !== 48'd0) begin bad++; $display("FAIL reset_cmp_a got=%h exp=0", cmp_a); end
    total++; if (cmp_b !== 48'd0) begin bad++; $display("FAIL reset_cmp_b got=%h exp=0", cmp_b); end
    total++; if (match_count !== 32'd0) begin bad++; $display("FAIL reset_match_count got=%0d exp=0", match_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_distinct();
    int acc, base;
    reset_a();
    base = hv_edge_q.size();
    for (int i = 0; i < 100; i++) feed(48'(i) * 48'h1_0001, acc);
    repeat (6) @(posedge clk);
    #1;
    total++; if (hv_edge_q.size() !== base) begin bad++; $display("FAIL distinct_hits got=%0d exp=0", hv_edge_q.size() - base); end
    total++; if (hit_overflow !== 1'b0) begin bad++; $display("FAIL distinct_overflow got=%0b exp=0", hit_overflow); end
    total++; if (cmp_a !== 48'h63_0063) begin bad++; $display("FAIL distinct_cmp_a got=%h exp=630063", cmp_a); end
    total++; if (cmp_b !== 48'h5F_005F) begin bad++; $display("FAIL distinct_cmp_b got=%h exp=5f005f", cmp_b); end
    total++; if (match_count !== 32'd0) begin bad++; $display("FAIL distinct_match_count got=%0d exp=0", match_count); end
  endtask

  task automatic test_corrupt();
    int acc[24];
    int base, n;
    reset_a();
    base = hv_edge_q.size();
    for (int i = 0; i < 24; i++) feed((i == 9) ? 48'hDEAD_0000_BEEF : 48'(i % 4), acc[i]);
    repeat (8) @(posedge clk);
    #1;
    n = hv_edge_q.size() - base;
    total++; if (n !== 1) begin bad++; $display("FAIL corrupt_hit_cycles got=%0d exp=1", n); end
    if (n >= 1) begin
      total++; if (hv_addr_q[base] !== 32'd14) begin bad++; $display("FAIL corrupt_hit_addr got=%0d exp=14", hv_addr_q[base]); end
      total++; if (hv_edge_q[base] !== acc[21] + 3) begin bad++; $display("FAIL corrupt_hit_time got=%0d exp=%0d", hv_edge_q[base], acc[21] + 3); end
    end
    total++; if (match_count !== (MC_EN ? 32'd18 : 32'd0)) begin bad++; $display("FAIL corrupt_match_count got=%0d exp=%0d", match_count, MC_EN ? 18 : 0); end
  endtask

  task automatic test_midreset();
    int acc[16];
    int base, n, dummy;
    reset_a();
    for (int i = 0; i < 6; i++) feed(48'h100 + 48'(i % 4), dummy);
    // let one result land and keep another in flight across the reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    base = hv_edge_q.size();
    for (int i = 0; i < 4; i++) feed(48'h100 + 48'(i % 4), acc[i]);
    total++; if (cmp_a !== 48'd0) begin bad++; $display("FAIL midreset_no_issue_a got=%h exp=0", cmp_a); end
    total++; if (cmp_b !== 48'd0) begin bad++; $display("FAIL midreset_no_issue_b got=%h exp=0", cmp_b); end
    feed(48'h100, acc[4]);
    total++; if (cmp_a !== 48'h100) begin bad++; $display("FAIL midreset_first_issue got=%h exp=100", cmp_a); end
    for (int i = 5; i < 16; i++) feed(48'h100 + 48'(i % 4), acc[i]);
    repeat (8) @(posedge clk);
    #1;
    n = hv_edge_q.size() - base;
    total++; if (n !== 1) begin bad++; $display("FAIL midreset_hit_cycles got=%0d exp=1", n); end
    if (n >= 1) begin
      total++; if (hv_addr_q[base] !== 32'd4) begin bad++; $display("FAIL midreset_hit_addr got=%0d exp=4", hv_addr_q[base]); end
      total++; if (hv_edge_q[base] !== acc[11] + 3) begin bad++; $display("FAIL midreset_hit_time got=%0d exp=%0d", hv_edge_q[base], acc[11] + 3); end
    end
  endtask

  task automatic test_overflow();
    int nacc;
    logic ok;
    nacc = 0;
    b_hit_ready = 1'b0;
    b_rst = 1'b1;
    @(posedge clk);
    #1 b_rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      b_in_data = 48'(nacc % 4);
      b_in_valid = (nacc < 32);
      @(negedge clk);
      ok = b_in_ready;
      @(posedge clk);
      #1;
      if (ok && b_in_valid) nacc++;
    end
    b_in_valid = 1'b0;
    total++; if (b_hit_valid !== 1'b1) begin bad++; $display("FAIL ovf_hit_valid got=%0b exp=1", b_hit_valid); end
    total++; if (b_hit_addr !== 32'd4) begin bad++; $display("FAIL ovf_hit_addr got=%0d exp=4", b_hit_addr); end
    total++; if (b_hit_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", b_hit_overflow); end
    total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL ovf_in_ready got=%0b exp=0", b_in_ready); end
    total++; if (nacc !== 9) begin bad++; $display("FAIL ovf_accepted got=%0d exp=9", nacc); end
    total++; if (b_match_count !== (MC_EN ? 32'd5 : 32'd0)) begin bad++; $display("FAIL ovf_match_count got=%0d exp=%0d", b_match_count, MC_EN ? 5 : 0); end
    b_hit_ready = 1'b1;
    @(posedge clk);
    #1 b_hit_ready = 1'b0;
    total++; if (b_hit_valid !== 1'b0) begin bad++; $display("FAIL ovf_release_valid got=%0b exp=0", b_hit_valid); end
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL ovf_release_ready got=%0b exp=1", b_in_ready); end
    total++; if (b_hit_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", b_hit_overflow); end
  endtask

  initial begin
    reset_a();
    test_basic();
    test_reset();
    test_distinct();
    test_corrupt();
    test_midreset();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
